// File: rtl/pi_mac_pkg.sv
// rtl/pi_mac_pkg.sv - shared constants, state encoding and saturation helpers for pi_mac_sched
package pi_mac_pkg;

   localparam int DATA_W  = 16;
   localparam int ACC_W   = 48;
   localparam int SAT_LSB = 8;
   localparam int SAT_MSB = 23;
   localparam logic [DATA_W-1:0] SAT_POS = 16'h7fff;
   localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL0 = 2'd1,
      MUL1 = 2'd2,
      SAT  = 2'd3
   } state_t;

   // The window acc[47:23] must be pure sign extension for acc[23:8] to be exact
   function automatic logic sat_clamped(input logic [ACC_W-1:0] v);
      return !((&v[ACC_W-1:SAT_MSB]) || (~|v[ACC_W-1:SAT_MSB]));
   endfunction

   function automatic logic [DATA_W-1:0] sat16(input logic [ACC_W-1:0] v);
      if (sat_clamped(v))
         return v[ACC_W-1] ? SAT_NEG : SAT_POS;
      return v[SAT_MSB:SAT_LSB];
   endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin picker starting one past the last grant
module rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [ID_W-1:0]    last_id,
   output logic               gnt_vld,
   output logic [ID_W-1:0]    gnt_id
);

   logic [NUM_REQ-1:0] elig;

   assign elig = req & ~mask;

   // Walk farthest-to-nearest so the nearest eligible requester after last_id wins
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_id) + k) % NUM_REQ;
         if (elig[idx[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/pi_mac_sched.sv
// rtl/pi_mac_sched.sv - shared MAC/saturate datapath time-sliced among requesters; option PI_MAC_SCHED_SAT_FLAG_EN adds y_sat
module pi_mac_sched
   import pi_mac_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      c,
   input  logic                      r,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [DATA_W*NUM_REQ-1:0] a0,
   input  logic [DATA_W*NUM_REQ-1:0] b0,
   input  logic [DATA_W*NUM_REQ-1:0] a1,
   input  logic [DATA_W*NUM_REQ-1:0] b1,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         y,
   output logic                      y_vld,
   output logic [ID_W-1:0]           y_id,
`ifdef PI_MAC_SCHED_SAT_FLAG_EN
   output logic                      y_sat,
`endif
   output logic                      busy
);

   state_t                    state;
   logic [ID_W-1:0]           gnt_id;
   logic [ID_W-1:0]           last_id;
   logic [ACC_W-1:0]          acc;
   logic                      arb_vld;
   logic [ID_W-1:0]           arb_id;
   logic signed [DATA_W-1:0]  op_a;
   logic signed [DATA_W-1:0]  op_b;
   logic signed [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]          prod_ext;

   // The ack pulse coincides with the IDLE cycle after SAT, so it doubles as the
   // mask that keeps the just-served requester from being regranted before it can drop req
   rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (req),
      .mask    (ack),
      .last_id (last_id),
      .gnt_vld (arb_vld),
      .gnt_id  (arb_id)
   );

   // One multiplier: MUL0 uses the a0/b0 pair, MUL1 the a1/b1 pair of the granted slice
   always_comb begin
      op_a = a0[gnt_id*DATA_W +: DATA_W];
      op_b = b0[gnt_id*DATA_W +: DATA_W];
      if (state == MUL1) begin
         op_a = a1[gnt_id*DATA_W +: DATA_W];
         op_b = b1[gnt_id*DATA_W +: DATA_W];
      end
   end

   assign prod     = 32'(op_a) * 32'(op_b);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign busy     = (state != IDLE);

   // Job sequencer: arbitrate, two multiply-accumulate steps, saturate and publish
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state   <= IDLE;
         gnt_id  <= '0;
         last_id <= ID_W'(NUM_REQ-1);
         acc     <= '0;
         y       <= '0;
         y_vld   <= 1'b0;
         y_id    <= '0;
         ack     <= '0;
`ifdef PI_MAC_SCHED_SAT_FLAG_EN
         y_sat   <= 1'b0;
`endif
      end else begin
         y_vld <= 1'b0;
         ack   <= '0;
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  gnt_id  <= arb_id;
                  last_id <= arb_id;
                  state   <= MUL0;
               end
            end
            MUL0: begin
               acc   <= prod_ext;
               state <= MUL1;
            end
            MUL1: begin
               acc   <= acc + prod_ext;
               state <= SAT;
            end
            SAT: begin
               y           <= sat16(acc);
               y_id        <= gnt_id;
               y_vld       <= 1'b1;
               ack[gnt_id] <= 1'b1;
`ifdef PI_MAC_SCHED_SAT_FLAG_EN
               y_sat       <= sat_clamped(acc);
`endif
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pi_mac_sched.sv
// tb/tb_pi_mac_sched.sv - directed self-checking bench for pi_mac_sched
module tb_pi_mac_sched;

   logic        c;
   logic        r;
   logic [3:0]  req;
   logic [63:0] a0, b0, a1, b1;
   logic [3:0]  ack;
   logic [15:0] y;
   logic        y_vld;
   logic [1:0]  y_id;
   logic        busy;
`ifdef PI_MAC_SCHED_SAT_FLAG_EN
   logic        y_sat;
`endif

   int total = 0;
   int bad   = 0;
   int n;

   pi_mac_sched #(.NUM_REQ(4)) dut (
      .c     (c),
      .r     (r),
      .req   (req),
      .a0    (a0),
      .b0    (b0),
      .a1    (a1),
      .b1    (b1),
      .ack   (ack),
      .y     (y),
      .y_vld (y_vld),
      .y_id  (y_id),
`ifdef PI_MAC_SCHED_SAT_FLAG_EN
      .y_sat (y_sat),
`endif
      .busy  (busy)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int id, input logic [15:0] va0, input logic [15:0] vb0,
                          input logic [15:0] va1, input logic [15:0] vb1);
      a0[16*id +: 16] = va0;
      b0[16*id +: 16] = vb0;
      a1[16*id +: 16] = va1;
      b1[16*id +: 16] = vb1;
   endtask

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic wait_vld(input int max_cyc, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!y_vld && cnt < max_cyc);
   endtask

   task automatic check_sat(input string tag, input logic exp);
`ifdef PI_MAC_SCHED_SAT_FLAG_EN
      chk(tag, 32'(y_sat), 32'(exp));
`else
      if (exp === 1'bx) $display("unused %s", tag);
`endif
   endtask

   // Single-requester job: check 4-clock latency, result, id, ack and the following idle cycle
   task automatic job(input string tag, input int id,
                      input logic [15:0] va0, input logic [15:0] vb0,
                      input logic [15:0] va1, input logic [15:0] vb1,
                      input logic [15:0] exp_y, input logic exp_sat);
      set_ops(id, va0, vb0, va1, vb1);
      req = 4'(1 << id);
      wait_vld(12, n);
      chk({tag, "_lat"}, 32'(n), 32'd4);
      chk({tag, "_vld"}, 32'(y_vld), 32'd1);
      chk({tag, "_y"}, 32'(y), 32'(exp_y));
      chk({tag, "_id"}, 32'(y_id), 32'(id));
      chk({tag, "_ack"}, 32'(ack), 32'(1 << id));
      check_sat({tag, "_sat"}, exp_sat);
      req = 4'b0000;
      tick();
      chk({tag, "_vld_drop"}, 32'(y_vld), 32'd0);
      chk({tag, "_ack_drop"}, 32'(ack), 32'd0);
      chk({tag, "_y_hold"}, 32'(y), 32'(exp_y));
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [1:0] exp_order [5];
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      r   = 1'b1;
      req = 4'b0000;
      a0  = '0;
      b0  = '0;
      a1  = '0;
      b1  = '0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_vld", 32'(y_vld), 32'd0);
      chk("rst_id", 32'(y_id), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      r = 1'b0;
      tick();

      job("t1_unit",      0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0);
      job("t2_pos_clamp", 1, 16'h7fff, 16'h7fff, 16'h0000, 16'h0000, 16'h7fff, 1'b1);
      job("t2_neg_clamp", 1, 16'h8000, 16'h7fff, 16'h0000, 16'h0000, 16'h8000, 1'b1);
      job("t3_pos_edge",  3, 16'h7fff, 16'h0100, 16'h0001, 16'h00ff, 16'h7fff, 1'b0);
      job("t3_pos_over",  2, 16'h0800, 16'h1000, 16'h0000, 16'h0000, 16'h7fff, 1'b1);
      job("t4_cancel",    0, 16'h4000, 16'h4000, 16'hc000, 16'h4000, 16'h0000, 1'b0);
      job("neg_small",    1, 16'hff00, 16'h0100, 16'h0000, 16'h0000, 16'hff00, 1'b0);
      job("neg_edge",     2, 16'h8000, 16'h0100, 16'h0000, 16'h0000, 16'h8000, 1'b0);
      job("neg_over",     3, 16'h8000, 16'h0100, 16'hffff, 16'h0001, 16'h8000, 1'b1);

      // All four requesting: last grant was 3, so service starts at 0 and rotates
      for (int i = 0; i < 4; i++)
         set_ops(i, 16'((i + 1) << 8), 16'h0100, 16'h0000, 16'h0000);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_vld(12, n);
         chk($sformatf("t5_gap%0d", k), 32'(n), 32'd4);
         chk($sformatf("t5_id%0d", k), 32'(y_id), 32'(exp_order[k]));
         chk($sformatf("t5_y%0d", k), 32'(y), 32'((int'(exp_order[k]) + 1) << 8));
         chk($sformatf("t5_ack%0d", k), 32'(ack), 32'(1 << exp_order[k]));
      end
      req = 4'b0000;
      tick();
      chk("t5_stop", 32'(busy), 32'd0);

      // Reset in the middle of a job for requester 2
      set_ops(2, 16'h0300, 16'h0100, 16'h0000, 16'h0000);
      set_ops(0, 16'h0500, 16'h0100, 16'h0000, 16'h0000);
      req = 4'b0100;
      tick();
      chk("t6_busy_mul0", 32'(busy), 32'd1);
      tick();
      r = 1'b1;
      #1;
      chk("t6_busy_rst", 32'(busy), 32'd0);
      chk("t6_y_rst", 32'(y), 32'd0);
      chk("t6_ack_rst", 32'(ack), 32'd0);
      chk("t6_vld_rst", 32'(y_vld), 32'd0);
      tick();
      chk("t6_ack_hold", 32'(ack), 32'd0);
      req = 4'b0101;
      r   = 1'b0;
      wait_vld(12, n);
      chk("t6_lat", 32'(n), 32'd4);
      chk("t6_first_id", 32'(y_id), 32'd0);
      chk("t6_first_y", 32'(y), 32'h0500);
      req = 4'b0100;
      wait_vld(12, n);
      chk("t6_next_lat", 32'(n), 32'd4);
      chk("t6_next_id", 32'(y_id), 32'd2);
      chk("t6_next_y", 32'(y), 32'h0300);
      req = 4'b0000;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
